// File: rtl/riscv_structures.sv
// Shared pipeline types: hazard-controller state and operand forward-select encodings.
package riscv_structures;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand forward select for one execute input; purely combinational.
// The memory stage is the younger producer, so it wins over writeback.
module fwd_unit
  import riscv_structures::*;
(
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  fwd_sel_e sel_e;

  always_comb begin
    sel_e = FWD_RF;
    if (use_rs && rs != 5'd0) begin
      if (mem_reg_write && mem_rd == rs) begin
        sel_e = FWD_MEM;
      end else if (wb_reg_write && wb_rd == rs) begin
        sel_e = FWD_WB;
      end
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush and forwarding control for the 5-stage pipeline, zero-cycle response.
// Priority mem_busy > redirect > load-use; FSM sequences multi-cycle flushes and memory waits.
module pipeline_hazard_ctrl
  import riscv_structures::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  hz_state_e        state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic       load_use, run_eval, accept;
  logic       stall_all, stall_lu, flush, bubble;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  fwd_unit u_fwd_a (
    .rs(id_rs1), .use_rs(id_use_rs1),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .sel(fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .rs(id_rs2), .use_rs(id_use_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .sel(fwd_b_raw)
  );

  assign load_use = ex_mem_read && ex_reg_write && ex_rd != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    run_eval  = 1'b0;
    accept    = 1'b0;
    stall_all = 1'b0;
    stall_lu  = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;

    case (state_q)
      RUN: run_eval = 1'b1;
      FLUSH: begin
        // Decode holds a wrong-path instruction here, so load-use is not evaluated.
        flush = 1'b1;
        if (mem_busy) begin
          stall_all = 1'b1;
        end else if (redirect) begin
          accept = 1'b1;
          bubble = 1'b1;
          fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q <= 3'd1) begin
          state_d = RUN;
          fcnt_d  = 3'd0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      MEMWAIT: begin
        // The exit cycle behaves as RUN so a redirect held by execute is taken at once.
        if (mem_busy) stall_all = 1'b1;
        else          run_eval  = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (run_eval) begin
      state_d = RUN;
      if (mem_busy) begin
        stall_all = 1'b1;
        state_d   = MEMWAIT;
      end else if (redirect) begin
        accept = 1'b1;
        flush  = 1'b1;
        bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end
      end else if (load_use) begin
        stall_lu = 1'b1;
        bubble   = 1'b1;
      end
    end

    stall_count_d = stall_count_q;
    if ((stall_all || stall_lu) && stall_count_q != '1) stall_count_d = stall_count_q + CNT_ONE;
    flush_count_d = flush_count_q;
    if (accept && flush_count_q != '1) flush_count_d = flush_count_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fcnt_q        <= 3'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_if    = rst_n & (stall_all | stall_lu);
  assign stall_id    = rst_n & (stall_all | stall_lu);
  assign stall_ex    = rst_n & stall_all;
  assign stall_mem   = rst_n & stall_all;
  assign bubble_ex   = rst_n & bubble;
  assign flush_id    = rst_n & flush;
  assign fwd_a_sel   = rst_n ? fwd_a_raw : 2'd0;
  assign fwd_b_sel   = rst_n ? fwd_b_raw : 2'd0;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against a remaining-cycles model.
module tb_pipeline_hazard_ctrl;

  localparam int FC      = 3;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
  logic          mem_reg_write, wb_reg_write, redirect, mem_busy;
  logic          stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  // Model state: flush cycles still owed after this one, and whether memory is holding us.
  int m_left = 0, n_left;
  bit m_wait = 0, n_wait;
  int m_stalls = 0, m_flushes = 0;
  bit acc, clr;
  logic e_sif, e_sid, e_sex, e_smem, e_bub, e_fid;
  logic [1:0] e_fa, e_fb;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .redirect(redirect), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] rs, input logic use_rs);
    if (!use_rs || rs == 5'd0) return 2'd0;
    if (mem_reg_write && mem_rd == rs) return 2'd1;
    if (wb_reg_write && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic idle();
    rst_n = 1'b1;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    redirect = 0; mem_busy = 0;
  endtask

  task automatic predict();
    bit lu, run;
    {e_sif, e_sid, e_sex, e_smem, e_bub, e_fid} = '0;
    n_left = m_left; n_wait = m_wait; acc = 0; clr = 0;
    e_fa = fwd_of(id_rs1, id_use_rs1);
    e_fb = fwd_of(id_rs2, id_use_rs2);
    lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst_n) begin
      e_fa = 0; e_fb = 0; n_left = 0; n_wait = 0; clr = 1;
    end else begin
      run = 1;
      if (m_wait) begin
        if (mem_busy) begin {e_sif, e_sid, e_sex, e_smem} = '1; run = 0; end
        else n_wait = 0;
      end else if (m_left > 0) begin
        run = 0; e_fid = 1;
        if (mem_busy) {e_sif, e_sid, e_sex, e_smem} = '1;
        else if (redirect) begin e_bub = 1; acc = 1; n_left = FC - 1; end
        else n_left = m_left - 1;
      end
      if (run) begin
        if (mem_busy) begin {e_sif, e_sid, e_sex, e_smem} = '1; n_wait = 1; end
        else if (redirect) begin e_fid = 1; e_bub = 1; acc = 1; n_left = FC - 1; end
        else if (lu) begin e_sif = 1; e_sid = 1; e_bub = 1; end
      end
    end
  endtask

  // One clock: check combinational outputs before the edge, counters just after it.
  task automatic cyc();
    #1;
    predict();
    chk("stall_if", stall_if, e_sif);
    chk("stall_id", stall_id, e_sid);
    chk("stall_ex", stall_ex, e_sex);
    chk("stall_mem", stall_mem, e_smem);
    chk("bubble_ex", bubble_ex, e_bub);
    chk("flush_id", flush_id, e_fid);
    chk("fwd_a_sel", fwd_a_sel, e_fa);
    chk("fwd_b_sel", fwd_b_sel, e_fb);
    @(posedge clk);
    if (clr) begin
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (e_sif && m_stalls < CNT_MAX) m_stalls++;
      if (acc && m_flushes < CNT_MAX) m_flushes++;
    end
    m_left = n_left; m_wait = n_wait;
    #1;
    chk("stall_count", stall_count, m_stalls);
    chk("flush_count", flush_count, m_flushes);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Forwarding: memory stage beats writeback; x0 is never forwarded.
    mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1; id_rs1 = 5; id_use_rs1 = 1;
    #1 chk("plan_fwd_mem", fwd_a_sel, 2'd1);
    cyc();
    mem_rd = 0; wb_rd = 0; id_rs1 = 0;
    #1 chk("plan_fwd_x0", fwd_a_sel, 2'd0);
    cyc();
    mem_reg_write = 0; id_rs2 = 9; id_use_rs2 = 1; wb_rd = 9;
    cyc();

    // Load-use: one stall cycle, one bubble.
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    #1 chk("plan_lu_bubble", bubble_ex, 1'b1);
    cyc();
    idle();
    cyc();
    chk("plan_lu_count", stall_count, 1);

    // Redirect: flush_id for FC cycles.
    redirect = 1;
    cyc();
    redirect = 0;
    cyc(); cyc();
    #1 chk("plan_redir_done", flush_id, 1'b0);
    chk("plan_redir_count", flush_count, 1);
    cyc();

    // mem_busy while the last flush cycle is pending.
    redirect = 1; cyc();
    redirect = 0; cyc();
    mem_busy = 1;
    repeat (4) begin
      #1 chk("plan_busy_flush", flush_id, 1'b1);
      cyc();
    end
    mem_busy = 0;
    #1 chk("plan_busy_last_flush", flush_id, 1'b1);
    cyc();
    #1 chk("plan_busy_back_run", flush_id, 1'b0);
    cyc();

    // Redirect and load-use together: redirect wins.
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; redirect = 1;
    #1 chk("plan_redir_over_lu", stall_if, 1'b0);
    cyc();
    redirect = 0;
    cyc(); cyc(); cyc();

    // Reset in the middle of a flush.
    idle();
    redirect = 1; cyc();
    redirect = 0; cyc();
    rst_n = 0;
    #1 chk("plan_rst_flush", flush_id, 1'b0);
    cyc();
    chk("plan_rst_stall_cnt", stall_count, 0);
    chk("plan_rst_flush_cnt", flush_count, 0);
    idle();
    cyc();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_use_rs1    = 1'($urandom);
      id_use_rs2    = 1'($urandom);
      ex_rd         = 5'($urandom_range(0, 7));
      ex_reg_write  = 1'($urandom);
      ex_mem_read   = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 7));
      mem_reg_write = 1'($urandom);
      wb_rd         = 5'($urandom_range(0, 7));
      wb_reg_write  = 1'($urandom);
      redirect      = ($urandom_range(0, 7) == 0);
      mem_busy      = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
